// File: rtl/spi_slave_sel_ctrl.sv
// Slave-select sequencer for a shared SPI bus.
// A selection changes only while the MCU bus is idle. Between two
// selections a guard gap is inserted with no slave selected. The one-hot
// sw_flag bus steers the MISO return mux. The MCU chip select is gated
// onto the single selected slave_cs_n line.
//
// Handshake: sel_req is a one-cycle strobe, and sel_idx is valid only in
// that cycle. There is no back-pressure. A request that arrives while
// sel_busy is high replaces the pending target. Every accepted request
// chain ends in exactly one sel_ack pulse. A rejected index produces a
// sel_err pulse instead.
module spi_slave_sel_ctrl #(
    parameter int NUM_SLAVES  = 7,
    parameter int GUARD_CYC   = 8,
    parameter int SYNC_STAGES = 2,
    parameter int IDXW        = $clog2(NUM_SLAVES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sel_req,
    input  logic [IDXW-1:0]       sel_idx,
    input  logic                  mcu_spi_cs_n,
    output logic [NUM_SLAVES-1:0] sw_flag,
    output logic [NUM_SLAVES-1:0] slave_cs_n,
    output logic                  sel_busy,
    output logic                  sel_ack,
    output logic                  sel_err,
    output logic                  cs_viol
);

    localparam int CNTW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [CNTW-1:0] GUARD_LOAD = CNTW'(GUARD_CYC - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        WAIT_BUS = 2'd2,
        GUARD    = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic [IDXW-1:0]         cur, cur_nxt;
    logic [IDXW-1:0]         pend, pend_nxt;
    logic [CNTW-1:0]         cnt, cnt_nxt;
    logic [NUM_SLAVES-1:0]   sw_nxt;
    logic                    ack_nxt, err_nxt, viol_nxt;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    cs_sync, cs_sync_d, cs_fall;
    logic [IDXW:0]           idx_ext;
    logic                    req_ok, req_bad;
    logic [IDXW-1:0]         target;

    // Slave number to one-hot select: slave 1 is bit 0, and index 0 gives all zeros.
    function automatic logic [NUM_SLAVES-1:0] onehot(input logic [IDXW-1:0] idx);
        logic [NUM_SLAVES-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx == IDXW'(i + 1)) v[i] = 1'b1;
        end
        return v;
    endfunction

    assign cs_sync    = sync_q[SYNC_STAGES-1];
    assign cs_fall    = cs_sync_d & ~cs_sync;
    assign idx_ext    = {1'b0, sel_idx};
    assign req_bad    = sel_req && (idx_ext > (IDXW + 1)'(NUM_SLAVES));
    assign req_ok     = sel_req && !req_bad;
    assign sel_busy   = (state == WAIT_BUS) || (state == GUARD);
    // Uses the raw CS so that frame edges reach the slave without synchronizer delay.
    assign slave_cs_n = {NUM_SLAVES{mcu_spi_cs_n}} | ~sw_flag;

    // Bring the asynchronous MCU chip select into the clk domain, and keep the previous value for fall detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '1;
            cs_sync_d <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], mcu_spi_cs_n};
            cs_sync_d <= cs_sync;
        end
    end

    // State, target registers, guard counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur     <= '0;
            pend    <= '0;
            cnt     <= '0;
            sw_flag <= '0;
            sel_ack <= 1'b0;
            sel_err <= 1'b0;
            cs_viol <= 1'b0;
        end else begin
            state   <= state_nxt;
            cur     <= cur_nxt;
            pend    <= pend_nxt;
            cnt     <= cnt_nxt;
            sw_flag <= sw_nxt;
            sel_ack <= ack_nxt;
            sel_err <= err_nxt;
            cs_viol <= viol_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        pend_nxt  = pend;
        cnt_nxt   = cnt;
        sw_nxt    = sw_flag;
        ack_nxt   = 1'b0;
        err_nxt   = req_bad;
        viol_nxt  = 1'b0;
        target    = req_ok ? sel_idx : pend;

        case (state)
            IDLE: begin
                sw_nxt  = '0;
                cur_nxt = '0;
                if (req_ok) begin
                    if (sel_idx == '0) begin
                        ack_nxt = 1'b1;
                    end else begin
                        pend_nxt = sel_idx;
                        if (cs_sync) begin
                            state_nxt = GUARD;
                            cnt_nxt   = GUARD_LOAD;
                        end else begin
                            state_nxt = WAIT_BUS;
                        end
                    end
                end
            end

            ACTIVE: begin
                if (req_ok) begin
                    if (sel_idx == cur) begin
                        ack_nxt = 1'b1;
                    end else begin
                        pend_nxt = sel_idx;
                        if (cs_sync) begin
                            state_nxt = GUARD;
                            cnt_nxt   = GUARD_LOAD;
                            sw_nxt    = '0;
                        end else begin
                            state_nxt = WAIT_BUS;
                        end
                    end
                end
            end

            WAIT_BUS: begin
                // The current slave stays selected until its frame ends.
                if (req_ok) pend_nxt = sel_idx;
                if (cs_sync) begin
                    state_nxt = GUARD;
                    cnt_nxt   = GUARD_LOAD;
                    sw_nxt    = '0;
                end
            end

            GUARD: begin
                sw_nxt   = '0;
                viol_nxt = cs_fall;
                if (req_ok) pend_nxt = sel_idx;
                if (cnt == '0) begin
                    // A request in the final guard cycle still counts as the last word.
                    ack_nxt = 1'b1;
                    cur_nxt = target;
                    if (target != '0) begin
                        state_nxt = ACTIVE;
                        sw_nxt    = onehot(target);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                sw_nxt    = '0;
            end
        endcase
    end

endmodule
